// File: rtl/sigmoid_backward.sv
// sigmoid_backward: local sigmoid gradient grad_in = grad_out * y * (1 - y),
// computed in a 3-stage fixed-point pipeline under one global valid/ready stall.
module sigmoid_backward #(
  parameter int Y_W    = 17,
  parameter int GRAD_W = 18,
  parameter int FRAC   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Y_W-1:0]    y,
  input  logic [GRAD_W-1:0] grad_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GRAD_W-1:0] grad_in,
  output logic              range_err,
  input  logic              err_clr
);

  localparam int D_W = FRAC - 1;           // y*(1-y) never exceeds 0.25
  localparam int PW  = 2 * Y_W;
  localparam int GW  = GRAD_W + D_W + 1;   // signed grad times zero-extended d

  localparam logic [Y_W-1:0]       ONE    = Y_W'(1 << FRAC);
  localparam logic [PW-1:0]        HALF_U = PW'(1 << (FRAC - 1));
  localparam logic signed [GW-1:0] HALF_S = GW'(1 << (FRAC - 1));

  logic                     adv;
  logic                     v1, v2;
  logic [Y_W-1:0]           yc1, om1;
  logic [GRAD_W-1:0]        g1, g2;
  logic [D_W-1:0]           d2;

  logic                     y_over;
  logic [Y_W-1:0]           yc_next;
  logic [PW-1:0]            yo_prod;
  logic [D_W-1:0]           d_next;
  logic signed [GW-1:0]     gd_prod;
  logic [GRAD_W-1:0]        grad_next;

  // Single stall signal for every stage; in_ready never looks at in_valid.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign y_over  = y > ONE;
  assign yc_next = y_over ? ONE : y;

  assign yo_prod = PW'(yc1) * PW'(om1);
  assign d_next  = D_W'((yo_prod + HALF_U) >> FRAC);

  // Arithmetic shift after adding one half gives round-half-up (ties to +inf).
  assign gd_prod   = GW'($signed(g2)) * GW'($signed({1'b0, d2}));
  assign grad_next = GRAD_W'((gd_prod + HALF_S) >>> FRAC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      grad_in   <= '0;
      range_err <= 1'b0;
    end else begin
      if (adv) begin
        v1        <= in_valid;
        v2        <= v1;
        out_valid <= v2;
        if (v2) grad_in <= grad_next;
      end
      if (in_valid && adv && y_over) range_err <= 1'b1;
      else if (err_clr)              range_err <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits qualify them, so
  // their contents while invalid are don't-care and the reset tree stays small.
  always_ff @(posedge clk) begin
    if (adv) begin
      yc1 <= yc_next;
      om1 <= ONE - yc_next;
      g1  <= grad_out;
      d2  <= d_next;
      g2  <= g1;
    end
  end

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed and randomised checks of sigmoid_backward: values, rounding,
// latency, stall behaviour, range_err and mid-stream reset.
module tb_sigmoid_backward;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] y;
  logic [17:0] grad_out;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] grad_in;
  logic        range_err;
  logic        err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  sigmoid_backward #(.Y_W(17), .GRAD_W(18), .FRAC(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .grad_out (grad_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grad_in  (grad_in),
    .range_err(range_err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference used only by the random stream: round-half-up at both stages.
  function automatic logic [17:0] ref_grad(input logic [16:0] yy, input logic [17:0] gg);
    longint yc, om, d, q;
    yc = (yy > 17'd65536) ? 64'sd65536 : longint'(yy);
    om = 65536 - yc;
    d  = (yc * om + 32768) >>> 16;
    q  = (longint'($signed(gg)) * d + 32768) >>> 16;
    return q[17:0];
  endfunction

  // Drive inputs after a falling edge, then sample outputs 1 time unit later.
  task automatic drive(input logic iv, input logic [16:0] yy, input logic [17:0] gg,
                       input logic ordy, input logic clr,
                       output logic ir, output logic ov, output logic [17:0] gi);
    @(negedge clk);
    in_valid  = iv;
    y         = yy;
    grad_out  = gg;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    ir = in_ready;
    ov = out_valid;
    gi = grad_in;
  endtask

  task automatic drain();
    logic ir, ov;
    logic [17:0] gi;
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (grad_in !== 18'd0) begin n_bad++; $display("FAIL reset_grad_in: got %0d want 0", grad_in); end
    n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL reset_range_err: got %b want 0", range_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    logic ir, ov;
    logic [17:0] gi, res;
    int lat;
    drive(1'b1, 17'd32768, 18'd65536, 1'b1, 1'b0, ir, ov, gi);
    n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL lat_accept: in_ready %b want 1", ir); end
    lat = 0;
    res = 18'h3ffff;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
      if (ov) begin lat = i; res = gi; end
    end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL lat_cycles: got %0d want 3", lat); end
    n_cmp++; if (res !== 18'd16384) begin n_bad++; $display("FAIL lat_value: got %0d want 16384", res); end
    drain();
  endtask

  task automatic test_values();
    logic ir, ov;
    logic [17:0] gi;
    logic [16:0] vy [7];
    logic [17:0] vg [7];
    logic [17:0] ve [7];
    int k, nout;
    vy = '{17'd32768, 17'd0,      17'd65536, 17'd16384, 17'd32768, 17'd32768, 17'd32768};
    vg = '{-18'sd65536, 18'd65536, 18'd65536, 18'd65536, 18'd2,    -18'sd2,   -18'sd3};
    ve = '{-18'sd16384, 18'd0,     18'd0,     18'd12288, 18'd1,    18'd0,     -18'sd1};
    k = 0;
    nout = 0;
    for (int c = 0; c < 40 && nout < 7; c++) begin
      drive(k < 7, (k < 7) ? vy[k] : '0, (k < 7) ? vg[k] : '0, 1'b1, 1'b0, ir, ov, gi);
      if (ov && nout < 7) begin
        n_cmp++;
        if (gi !== ve[nout]) begin n_bad++; $display("FAIL value_%0d: got %0d want %0d", nout, $signed(gi), $signed(ve[nout])); end
        nout++;
      end
      if (k < 7 && ir) k++;
    end
    n_cmp++; if (nout != 7) begin n_bad++; $display("FAIL value_count: got %0d want 7", nout); end
    n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL value_no_err: range_err %b want 0", range_err); end
    drain();
  endtask

  task automatic test_range_err();
    logic ir, ov, got;
    logic [17:0] gi, res;
    drive(1'b1, 17'd70000, 18'd65536, 1'b1, 1'b0, ir, ov, gi);
    drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
    n_cmp++; if (range_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", range_err); end
    got = 1'b0;
    res = 18'h3ffff;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
      if (ov && !got) begin got = 1'b1; res = gi; end
    end
    n_cmp++; if (res !== 18'd0) begin n_bad++; $display("FAIL err_value: got %0d want 0", res); end
    n_cmp++; if (range_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", range_err); end
    drive(1'b0, '0, '0, 1'b1, 1'b1, ir, ov, gi);
    drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
    n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", range_err); end
    drive(1'b1, 17'd70000, 18'd100, 1'b1, 1'b1, ir, ov, gi);
    drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
    n_cmp++; if (range_err !== 1'b1) begin n_bad++; $display("FAIL err_set_wins: got %b want 1", range_err); end
    drive(1'b0, '0, '0, 1'b1, 1'b1, ir, ov, gi);
    drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
    n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL err_clear2: got %b want 0", range_err); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic ir, ov, ordy, stall_seen, dropped;
    logic [17:0] gi, held;
    logic [16:0] by [6];
    logic [17:0] bg [6];
    logic [17:0] be [6];
    int k, nout;
    by = '{17'd32768, 17'd16384, 17'd49152,   17'd32768, 17'd32768, 17'd65536};
    bg = '{18'd65536, 18'd65536, -18'sd65536, 18'd3,     -18'sd3,   18'd1000};
    be = '{18'd16384, 18'd12288, -18'sd12288, 18'd1,     -18'sd1,   18'd0};
    k = 0;
    nout = 0;
    stall_seen = 1'b0;
    dropped = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && nout < 6; c++) begin
      ordy = !(c >= 2 && c <= 7);
      drive(k < 6, (k < 6) ? by[k] : '0, (k < 6) ? bg[k] : '0, ordy, 1'b0, ir, ov, gi);
      if (k < 6 && !ir && !dropped) begin
        dropped = 1'b1;
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL b2b_held: in_ready fell with %0d accepted, want 3", k); end
      end
      if (ov && !ordy) begin
        if (!stall_seen) begin stall_seen = 1'b1; held = gi; end
        else begin
          n_cmp++; if (gi !== held) begin n_bad++; $display("FAIL b2b_stable: grad_in %0d want %0d", $signed(gi), $signed(held)); end
        end
      end
      if (ov && ordy && nout < 6) begin
        n_cmp++;
        if (gi !== be[nout]) begin n_bad++; $display("FAIL b2b_value_%0d: got %0d want %0d", nout, $signed(gi), $signed(be[nout])); end
        nout++;
      end
      if (k < 6 && ir) k++;
    end
    n_cmp++; if (!dropped) begin n_bad++; $display("FAIL b2b_drop: in_ready got 1 throughout want 0 during stall"); end
    n_cmp++; if (nout != 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", nout); end
    drain();
  endtask

  task automatic test_random();
    logic ir, ov, iv, ordy;
    logic [16:0] yy;
    logic [17:0] gi, gg, ex;
    logic [17:0] q [$];
    int sent, recvd;
    sent = 0;
    recvd = 0;
    for (int c = 0; c < 20000 && recvd < 1000; c++) begin
      iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      yy   = ($urandom_range(0, 9) == 0) ? 17'($urandom_range(65537, 90000)) : 17'($urandom_range(0, 65536));
      gg   = 18'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      drive(iv, yy, gg, ordy, 1'b0, ir, ov, gi);
      if (ov && ordy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: got beat %0d with none outstanding, want none", recvd);
        end else begin
          ex = q.pop_front();
          if (gi !== ex) begin n_bad++; $display("FAIL rand_beat_%0d: got %0d want %0d", recvd, $signed(gi), $signed(ex)); end
        end
        recvd++;
      end
      if (iv && ir) begin
        q.push_back(ref_grad(yy, gg));
        sent++;
      end
    end
    n_cmp++; if (recvd != 1000 || q.size() != 0) begin n_bad++; $display("FAIL rand_count: got %0d out / %0d pending want 1000 / 0", recvd, q.size()); end
    drain();
  endtask

  task automatic test_reset_midstream();
    logic ir, ov;
    logic [17:0] gi, res;
    int stale, lat;
    drive(1'b1, 17'd32768, 18'd65536, 1'b1, 1'b0, ir, ov, gi);
    drive(1'b1, 17'd16384, 18'd65536, 1'b1, 1'b0, ir, ov, gi);
    drive(1'b1, 17'd70000, 18'd65536, 1'b1, 1'b0, ir, ov, gi);
    drive(1'b0, '0, '0, 1'b0, 1'b0, ir, ov, gi);
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL rst_inflight: out_valid %b want 1", ov); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (grad_in !== 18'd0) begin n_bad++; $display("FAIL rst_grad_in: got %0d want 0", grad_in); end
    n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL rst_range_err: got %b want 0", range_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    #1 reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
      if (ov) stale++;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rst_stale: got %0d stale beats want 0", stale); end
    drive(1'b1, 17'd16384, -18'sd65536, 1'b1, 1'b0, ir, ov, gi);
    lat = 0;
    res = 18'h3ffff;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, ir, ov, gi);
      if (ov) begin lat = i; res = gi; end
    end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL rst_latency: got %0d want 3", lat); end
    n_cmp++; if (res !== -18'sd12288) begin n_bad++; $display("FAIL rst_value: got %0d want -12288", $signed(res)); end
    drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    y         = '0;
    grad_out  = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_latency();
    test_values();
    test_range_err();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
